// File: rtl/adc_spi_pkg.sv
// Shared definitions for the SPI ADC capture engine: FSM encoding, counter
// sizing and the parameter legality rule applied at elaboration.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIET,
    LEAD,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned MAX_CH         = 8;
  localparam int unsigned MAX_FRAME_BITS = 32;
  localparam int unsigned BIT_CNT_W      = $clog2(MAX_FRAME_BITS);

  // Width needed to hold 0..max_count, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic bit params_ok(input int unsigned num_ch,
                                   input int unsigned frame_bits,
                                   input int unsigned data_bits,
                                   input int unsigned sclk_div,
                                   input int unsigned quiet_cycles);
    return (num_ch >= 1) && (num_ch <= MAX_CH) && (data_bits >= 1) &&
           (frame_bits >= data_bits) && (frame_bits <= MAX_FRAME_BITS) &&
           (sclk_div >= 2) && (quiet_cycles >= 1);
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter driving a registered CPOL=1 sclk; ticks mark the edge
// on which sclk toggles. Parks sclk high while disabled or when told to stop.
module spi_sclk_div
  import adc_spi_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic stop_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned CW = cnt_w(SCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          half_end;

  assign half_end    = en_i && (cnt_q == CW'(SCLK_DIV - 1));
  assign rise_tick_o = half_end && !sclk_q;
  assign fall_tick_o = half_end && sclk_q;
  assign sclk_o      = sclk_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b1;
    end else if (half_end) begin
      cnt_d  = '0;
      // stop_i suppresses only the falling edge that would follow the last bit
      sclk_d = ~sclk_q | stop_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// Multi-channel SPI ADC capture: CS/SCLK generation, MSB-first shift, right-aligned
// sample extraction; results held on a valid/ready port with overrun flagging.
module adc_spi_capture
  import adc_spi_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned SCLK_DIV     = 20,
  parameter int unsigned QUIET_CYCLES = 300
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [NUM_CH-1:0]           sdin,
  output logic                        cs,
  output logic                        sclk,
  output logic [NUM_CH*DATA_BITS-1:0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        overrun,
  output logic                        busy
);

  localparam int unsigned QW = cnt_w(QUIET_CYCLES - 1);

  if (!params_ok(NUM_CH, FRAME_BITS, DATA_BITS, SCLK_DIV, QUIET_CYCLES)) begin : g_param_check
    $error("adc_spi_capture: illegal parameter set");
  end

  state_e                      state_q;
  logic [QW-1:0]               quiet_cnt_q;
  logic [BIT_CNT_W-1:0]        bit_cnt_q;
  logic                        cs_q;
  logic                        busy_q;
  logic [NUM_CH*DATA_BITS-1:0] dout_q;
  logic                        dout_valid_q;
  logic                        overrun_q;
  logic [DATA_BITS-1:0]        sr_q [NUM_CH];

  logic sclk_en, last_bit, rise_tick, fall_tick;

  assign sclk_en  = (state_q == LEAD) || (state_q == SHIFT);
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

  spi_sclk_div #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_div (
    .clk_i      (clk),
    .rst_ni     (reset),
    .en_i       (sclk_en),
    .stop_i     (last_bit),
    .sclk_o     (sclk),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      quiet_cnt_q  <= '0;
      bit_cnt_q    <= '0;
      cs_q         <= 1'b1;
      busy_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) sr_q[k] <= '0;
    end else begin
      overrun_q <= 1'b0;
      if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (continuous || start) begin
            state_q     <= QUIET;
            busy_q      <= 1'b1;
            quiet_cnt_q <= '0;
          end
        end
        QUIET: begin
          if (quiet_cnt_q == QW'(QUIET_CYCLES - 1)) begin
            cs_q    <= 1'b0;
            state_q <= LEAD;
          end else begin
            quiet_cnt_q <= quiet_cnt_q + 1'b1;
          end
        end
        LEAD: begin
          if (fall_tick) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
          end
        end
        SHIFT: begin
          // Only the last DATA_BITS samples survive; leading zero bits fall off the top.
          if (rise_tick) begin
            for (int k = 0; k < NUM_CH; k++) sr_q[k] <= DATA_BITS'({sr_q[k], sdin[k]});
          end
          if (fall_tick) begin
            if (last_bit) begin
              cs_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          for (int k = 0; k < NUM_CH; k++) dout_q[k*DATA_BITS +: DATA_BITS] <= sr_q[k];
          dout_valid_q <= 1'b1;
          overrun_q    <= dout_valid_q && !dout_ready;
          quiet_cnt_q  <= '0;
          if (continuous) begin
            state_q <= QUIET;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cs         = cs_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed bench: two configurations of the capture engine, each fed by a
// behavioural ADC that shifts the next frame MSB-first on every sclk fall.
module tb_adc_spi_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Configuration A: 2 ch, 16-bit frames, 12 data bits, SCLK_DIV=2, QUIET=4
  logic        a_reset, a_start, a_cont, a_rdy;
  logic [1:0]  a_sdin;
  logic        a_cs, a_sclk, a_vld, a_ovr, a_busy;
  logic [23:0] a_dout;

  adc_spi_capture #(
    .NUM_CH(2), .FRAME_BITS(16), .DATA_BITS(12), .SCLK_DIV(2), .QUIET_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .continuous(a_cont), .sdin(a_sdin),
    .cs(a_cs), .sclk(a_sclk), .dout(a_dout), .dout_valid(a_vld), .dout_ready(a_rdy),
    .overrun(a_ovr), .busy(a_busy)
  );

  // Configuration B: 4 ch, 14-bit frames, all bits kept, SCLK_DIV=3, QUIET=4
  logic        b_reset, b_start, b_cont, b_rdy;
  logic [3:0]  b_sdin;
  logic        b_cs, b_sclk, b_vld, b_ovr, b_busy;
  logic [55:0] b_dout;

  adc_spi_capture #(
    .NUM_CH(4), .FRAME_BITS(14), .DATA_BITS(14), .SCLK_DIV(3), .QUIET_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .continuous(b_cont), .sdin(b_sdin),
    .cs(b_cs), .sclk(b_sclk), .dout(b_dout), .dout_valid(b_vld), .dout_ready(b_rdy),
    .overrun(b_ovr), .busy(b_busy)
  );

  // ADC model A: frame table indexed by frames since a_fbase, clamped to the last entry.
  logic [15:0] a_tab0 [4];
  logic [15:0] a_tab1 [4];
  logic [15:0] a_cur0, a_cur1;
  int a_fcount = 0, a_fbase = 0, a_bit = -1, a_idx;
  logic a_cs_prev = 1'b1, a_sclk_prev = 1'b1;
  initial forever begin
    @(posedge clk);
    #1;
    if (a_cs_prev === 1'b1 && a_cs === 1'b0) begin
      a_idx = a_fcount - a_fbase;
      if (a_idx > 3) a_idx = 3;
      if (a_idx < 0) a_idx = 0;
      a_cur0 = a_tab0[a_idx];
      a_cur1 = a_tab1[a_idx];
      a_bit = 15;
      a_fcount++;
    end
    if (a_sclk_prev === 1'b1 && a_sclk === 1'b0 && a_cs === 1'b0 && a_bit >= 0) begin
      a_sdin = {a_cur1[a_bit], a_cur0[a_bit]};
      a_bit--;
    end
    a_cs_prev = a_cs;
    a_sclk_prev = a_sclk;
  end

  // ADC model B: single frame table, one entry per channel.
  logic [13:0] b_tab [4];
  int b_bit = -1;
  logic b_cs_prev = 1'b1, b_sclk_prev = 1'b1;
  initial forever begin
    @(posedge clk);
    #1;
    if (b_cs_prev === 1'b1 && b_cs === 1'b0) b_bit = 13;
    if (b_sclk_prev === 1'b1 && b_sclk === 1'b0 && b_cs === 1'b0 && b_bit >= 0) begin
      for (int k = 0; k < 4; k++) b_sdin[k] = b_tab[k][b_bit];
      b_bit--;
    end
    b_cs_prev = b_cs;
    b_sclk_prev = b_sclk;
  end

  int a_ovr_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (a_ovr === 1'b1) a_ovr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic a_pulse_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_wait_cs_low();
    int t;
    t = 0;
    while (a_cs !== 1'b0 && t < 400) begin @(negedge clk); t++; end
  endtask

  task automatic a_count_cs_low(output int n);
    n = 0;
    while (a_cs === 1'b0 && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic a_wait_vld();
    int t;
    t = 0;
    while (a_vld !== 1'b1 && t < 400) begin @(negedge clk); t++; end
  endtask

  task automatic a_wait_idle();
    int t;
    t = 0;
    while (a_busy !== 1'b0 && t < 400) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    a_reset = 1'b0; b_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", a_cs); else n_pass++;
    n_checks++; if (a_sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", a_sclk); else n_pass++;
    n_checks++; if (a_dout !== 24'h0) $display("FAIL reset_dout got %h want 000000", a_dout); else n_pass++;
    n_checks++; if (a_vld !== 1'b0) $display("FAIL reset_valid got %b want 0", a_vld); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else n_pass++;
    n_checks++; if (a_ovr !== 1'b0) $display("FAIL reset_overrun got %b want 0", a_ovr); else n_pass++;
    n_checks++; if (b_cs !== 1'b1 || b_sclk !== 1'b1) $display("FAIL reset_b_pins got cs=%b sclk=%b want 1/1", b_cs, b_sclk); else n_pass++;
    n_checks++; if (b_dout !== 56'h0) $display("FAIL reset_b_dout got %h want 0", b_dout); else n_pass++;
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_shot();
    int n;
    a_fbase = a_fcount;
    a_tab0[0] = 16'h0ABC; a_tab1[0] = 16'h0123;
    a_cont = 1'b0; a_rdy = 1'b0;
    a_pulse_start();
    n_checks++; if (a_busy !== 1'b1) $display("FAIL single_busy_start got %b want 1", a_busy); else n_pass++;
    a_wait_cs_low();
    a_count_cs_low(n);
    n_checks++; if (n != 66) $display("FAIL single_cs_low got %0d cycles want 66", n); else n_pass++;
    @(negedge clk);
    n_checks++; if (a_vld !== 1'b1) $display("FAIL single_valid got %b want 1", a_vld); else n_pass++;
    n_checks++; if (a_dout !== 24'h123ABC) $display("FAIL single_dout got %h want 123abc", a_dout); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", a_busy); else n_pass++;
    n_checks++; if (a_ovr !== 1'b0) $display("FAIL single_overrun got %b want 0", a_ovr); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (a_vld !== 1'b1 || a_dout !== 24'h123ABC) $display("FAIL single_hold got vld=%b dout=%h want 1/123abc", a_vld, a_dout); else n_pass++;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    n_checks++; if (a_vld !== 1'b0) $display("FAIL single_accept got vld=%b want 0", a_vld); else n_pass++;
  endtask

  task automatic test_leading_bits();
    a_fbase = a_fcount;
    a_tab0[0] = 16'hF123; a_tab1[0] = 16'hF456;
    a_pulse_start();
    a_wait_vld();
    n_checks++; if (a_dout !== 24'h456123) $display("FAIL leading_bits got %h want 456123", a_dout); else n_pass++;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
  endtask

  task automatic test_continuous();
    logic [23:0] exp_d [3];
    int t_vld [3];
    int ovr_base;
    exp_d = '{24'h000FFF, 24'h001800, 24'hAAA555};
    a_fbase = a_fcount;
    a_tab0 = '{16'h0FFF, 16'h0800, 16'h0555, 16'h0000};
    a_tab1 = '{16'h0000, 16'h0001, 16'h0AAA, 16'h0000};
    ovr_base = a_ovr_cnt;
    a_rdy = 1'b1; a_cont = 1'b1;
    for (int f = 0; f < 3; f++) begin
      a_wait_vld();
      t_vld[f] = cyc;
      n_checks++; if (a_dout !== exp_d[f]) $display("FAIL cont_dout_%0d got %h want %h", f, a_dout, exp_d[f]); else n_pass++;
      @(negedge clk);
    end
    a_cont = 1'b0;
    n_checks++; if (t_vld[1] - t_vld[0] != 71) $display("FAIL cont_period_01 got %0d want 71", t_vld[1] - t_vld[0]); else n_pass++;
    n_checks++; if (t_vld[2] - t_vld[1] != 71) $display("FAIL cont_period_12 got %0d want 71", t_vld[2] - t_vld[1]); else n_pass++;
    a_wait_idle();
    @(negedge clk);
    n_checks++; if (a_ovr_cnt - ovr_base != 0) $display("FAIL cont_overrun got %0d pulses want 0", a_ovr_cnt - ovr_base); else n_pass++;
    a_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    int ovr_base, t;
    a_fbase = a_fcount;
    a_tab0 = '{16'h0111, 16'h0333, 16'h0000, 16'h0000};
    a_tab1 = '{16'h0222, 16'h0444, 16'h0000, 16'h0000};
    ovr_base = a_ovr_cnt;
    a_rdy = 1'b0; a_cont = 1'b1;
    a_wait_vld();
    n_checks++; if (a_dout !== 24'h222111) $display("FAIL bp_first got %h want 222111", a_dout); else n_pass++;
    a_wait_cs_low();
    a_cont = 1'b0;
    t = 0;
    while (a_ovr !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    n_checks++; if (a_dout !== 24'h444333 || a_vld !== 1'b1) $display("FAIL bp_overwrite got vld=%b dout=%h want 1/444333", a_vld, a_dout); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (a_ovr_cnt - ovr_base != 1) $display("FAIL bp_overrun_count got %0d want 1", a_ovr_cnt - ovr_base); else n_pass++;
    n_checks++; if (a_dout !== 24'h444333) $display("FAIL bp_hold got %h want 444333", a_dout); else n_pass++;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
    n_checks++; if (a_vld !== 1'b0) $display("FAIL bp_release got vld=%b want 0", a_vld); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    a_fbase = a_fcount;
    a_tab0[0] = 16'h0FFF; a_tab1[0] = 16'h0FFF;
    a_pulse_start();
    a_wait_cs_low();
    repeat (20) @(negedge clk);
    n_checks++; if (a_cs !== 1'b0) $display("FAIL midrst_in_frame got cs=%b want 0", a_cs); else n_pass++;
    a_reset = 1'b0;
    @(negedge clk);
    n_checks++; if (a_cs !== 1'b1 || a_sclk !== 1'b1) $display("FAIL midrst_pins got cs=%b sclk=%b want 1/1", a_cs, a_sclk); else n_pass++;
    n_checks++; if (a_busy !== 1'b0 || a_vld !== 1'b0) $display("FAIL midrst_state got busy=%b vld=%b want 0/0", a_busy, a_vld); else n_pass++;
    a_reset = 1'b1;
    repeat (2) @(negedge clk);
    a_fbase = a_fcount;
    a_tab0[0] = 16'h0321; a_tab1[0] = 16'h0654;
    a_pulse_start();
    a_wait_vld();
    n_checks++; if (a_dout !== 24'h654321) $display("FAIL midrst_recapture got %h want 654321", a_dout); else n_pass++;
    a_rdy = 1'b1;
    @(negedge clk);
    a_rdy = 1'b0;
  endtask

  task automatic test_param_sweep();
    int n, t;
    b_tab = '{14'h2A5C, 14'h1234, 14'h0F0F, 14'h3C01};
    b_cont = 1'b0; b_rdy = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    t = 0;
    while (b_cs !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    n = 0;
    while (b_cs === 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n_checks++; if (n != 87) $display("FAIL sweep_cs_low got %0d cycles want 87", n); else n_pass++;
    @(negedge clk);
    n_checks++; if (b_vld !== 1'b1 || b_busy !== 1'b0) $display("FAIL sweep_done got vld=%b busy=%b want 1/0", b_vld, b_busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b_dout[k*14 +: 14] !== b_tab[k]) $display("FAIL sweep_ch%0d got %h want %h", k, b_dout[k*14 +: 14], b_tab[k]);
      else n_pass++;
    end
    n_checks++; if (b_ovr !== 1'b0) $display("FAIL sweep_overrun got %b want 0", b_ovr); else n_pass++;
  endtask

  initial begin
    a_reset = 1'b0; a_start = 1'b0; a_cont = 1'b0; a_rdy = 1'b0;
    b_reset = 1'b0; b_start = 1'b0; b_cont = 1'b0; b_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_tab0[i] = '0; a_tab1[i] = '0; b_tab[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_leading_bits();
    test_continuous();
    test_backpressure();
    test_reset_mid_shift();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
